// File: rtl/crc32_pkg.sv
// Shared constants, state encoding and the byte-wide CRC-32 update used by the FCS arbiter.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Register value left after running a good frame plus its FCS through the engine
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        FCS  = 2'd2
    } arb_state_t;

    // Reflected CRC-32, data consumed LSB first, eight unrolled shift/xor steps
    function automatic logic [31:0] crc32_next_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: lowest requesting index at or above ptr, wrapping; one-hot out.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant
);

    logic found;
    int   idx;

    // Scan from the pointer upward, first requester found wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc32_fcs_arbiter.sv
// Frame-level round-robin arbiter sharing one CRC-32 engine; forwards payload then appends FCS.
//
//   state | meaning
//   IDLE  | no owner; grants the next requester with s_valid set
//   DATA  | forwarding payload bytes of the granted requester
//   FCS   | emitting the four inverted CRC bytes, LSB first
module crc32_fcs_arbiter
    import crc32_pkg::*;
#(
    parameter int          N_REQ    = 2,
    parameter logic [31:0] CRC_INIT = CRC32_INIT,
    parameter bit          FCS_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [8*N_REQ-1:0] s_data,
    input  logic [N_REQ-1:0]   s_valid,
    input  logic [N_REQ-1:0]   s_last,
    output logic [N_REQ-1:0]   s_ready,
    output logic [7:0]         m_data,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state, state_d;
    logic [N_REQ-1:0] grant_q, arb_grant;
    logic [PW-1:0]    g_idx, arb_idx, rr_ptr;
    logic [31:0]      crc, fcs_word;
    logic [1:0]       fcs_cnt;
    logic [7:0]       sel_data, fcs_byte;
    logic             out_free, sel_valid, sel_last;
    logic             accept, fcs_load, start, frame_done, m_valid_d;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req   (s_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    // One-hot arbiter result to binary index for the data mux
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) arb_idx = PW'(i);
        end
    end

    assign out_free   = ~m_valid | m_ready;
    assign sel_valid  = s_valid[g_idx];
    assign sel_last   = s_last[g_idx];
    assign sel_data   = s_data[8*int'(g_idx) +: 8];
    assign fcs_word   = ~crc;
    assign start      = (state == IDLE) && (|s_valid);
    assign frame_done = (state != IDLE) && (state_d == IDLE);
    assign m_valid_d  = accept | fcs_load | (m_valid & ~m_ready);
    assign grant      = grant_q;

    // FCS bytes leave least significant first
    always_comb begin
        case (fcs_cnt)
            2'd0:    fcs_byte = fcs_word[7:0];
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state logic; the last FCS byte returns to IDLE as soon as it is loaded
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (|s_valid) state_d = DATA;
            DATA: if (accept && sel_last) state_d = FCS_EN ? FCS : IDLE;
            FCS:  if (fcs_load && (fcs_cnt == 2'd3)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only the owner sees ready, and only when the output register can take a byte
    always_comb begin
        s_ready  = '0;
        accept   = 1'b0;
        fcs_load = 1'b0;
        case (state)
            DATA: begin
                s_ready = grant_q & {N_REQ{out_free}};
                accept  = out_free & sel_valid;
            end
            FCS:     fcs_load = out_free;
            default: ;
        endcase
    end

    // Output register: loads a payload or FCS byte, otherwise holds until taken downstream
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_data  <= sel_data;
            m_valid <= 1'b1;
            m_last  <= sel_last & ~FCS_EN;
        end else if (fcs_load) begin
            m_data  <= fcs_byte;
            m_valid <= 1'b1;
            m_last  <= (fcs_cnt == 2'd3);
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Grant, round-robin pointer, CRC register, FCS byte counter and busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= '0;
            g_idx   <= '0;
            rr_ptr  <= '0;
            crc     <= CRC_INIT;
            fcs_cnt <= 2'd0;
            busy    <= 1'b0;
        end else begin
            if (start) begin
                grant_q <= arb_grant;
                g_idx   <= arb_idx;
                crc     <= CRC_INIT;
                fcs_cnt <= 2'd0;
            end else if (frame_done) begin
                grant_q <= '0;
                rr_ptr  <= (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
            end
            if (accept)   crc     <= crc32_next_byte(crc, sel_data);
            if (fcs_load) fcs_cnt <= fcs_cnt + 2'd1;
            busy <= (state_d != IDLE) | m_valid_d;
        end
    end

endmodule
